classifier_result_reader: RTL and testbench

Output-side controller for the classifier. On request it pulses `start_conversion`. When the classifier reports `end_of_conversion`, it reads the output-layer activations back from the activation BRAM read port, one per cycle, and computes the argmax. It then presents the recognised digit and its score with a one-cycle valid pulse. It sits between the classifier/BRAM pair and the display or host logic.

---
 rtl/classifier_result_reader.sv | 133 +++++++++++++
 tb/tb_classifier_result_reader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/classifier_result_reader.sv
`default_nettype none
// ============================================================================
// Module   : classifier_result_reader
// Brief    : Issues a start pulse to the classifier, waits for end of
//            conversion, scans the output-layer activations from BRAM, and
//            reports the argmax digit and its score with a valid pulse.
// Revision : 1.0  initial release
// ============================================================================
module classifier_result_reader #(
    parameter int                    NUM_OUTPUTS         = 10,
    parameter int                    DATA_WIDTH          = 48,
    parameter int                    ADDR_WIDTH          = 32,
    parameter logic [ADDR_WIDTH-1:0] OUTPUT_BASE_ADDRESS = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_request,
    output logic                  start_conversion,
    input  logic                  end_of_conversion,
    output logic                  bram_read_enable,
    output logic [ADDR_WIDTH-1:0] bram_read_address,
    input  logic [DATA_WIDTH-1:0] bram_read_data,
    output logic                  busy,
    output logic                  result_valid,
    output logic [3:0]            result_digit,
    output logic [DATA_WIDTH-1:0] result_score
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_EOC = 3'd1;
    localparam logic [2:0] ST_READ     = 3'd2;
    localparam logic [2:0] ST_DRAIN    = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    localparam logic [3:0] LAST_IDX = 4'(NUM_OUTPUTS - 1);

    logic [2:0]            state_q, state_d;
    logic [3:0]            idx_q, idx_d;
    logic                  start_q, start_d;
    // Read-data tracking: a read issued in cycle c returns in cycle c+1.
    logic                  rvalid_q;
    logic [3:0]            ridx_q;
    logic [DATA_WIDTH-1:0] max_q, max_d;
    logic [3:0]            max_idx_q, max_idx_d;
    logic [3:0]            digit_q;
    logic [DATA_WIDTH-1:0] score_q;

    // Next-state and index counter; EOC takes priority over a start request.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (end_of_conversion) begin
                    state_d = ST_READ;
                    idx_d   = 4'd0;
                end else if (start_request) begin
                    state_d = ST_WAIT_EOC;
                    start_d = 1'b1;
                end
            end
            ST_WAIT_EOC: begin
                if (end_of_conversion) begin
                    state_d = ST_READ;
                    idx_d   = 4'd0;
                end
            end
            ST_READ: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                    idx_d   = 4'd0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Running argmax; index 0 seeds the max, later data must be strictly larger.
    always_comb begin
        max_d     = max_q;
        max_idx_d = max_idx_q;
        if (rvalid_q && ((ridx_q == 4'd0) || (bram_read_data > max_q))) begin
            max_d     = bram_read_data;
            max_idx_d = ridx_q;
        end
    end

    // State, counters, read tracking and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= 4'd0;
            start_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            ridx_q    <= 4'd0;
            max_q     <= '0;
            max_idx_q <= 4'd0;
            digit_q   <= 4'd0;
            score_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            start_q   <= start_d;
            rvalid_q  <= (state_q == ST_READ);
            ridx_q    <= idx_q;
            max_q     <= max_d;
            max_idx_q <= max_idx_d;
            // The last datum lands during DRAIN, so the result is taken from
            // the combinational max at that edge to be stable throughout DONE.
            if (state_q == ST_DRAIN) begin
                digit_q <= max_idx_d;
                score_q <= max_d;
            end
        end
    end

    assign start_conversion  = start_q;
    assign bram_read_enable  = (state_q == ST_READ);
    assign bram_read_address = bram_read_enable
                             ? (OUTPUT_BASE_ADDRESS + ADDR_WIDTH'(idx_q))
                             : '0;
    assign busy              = (state_q != ST_IDLE);
    assign result_valid      = (state_q == ST_DONE);
    assign result_digit      = digit_q;
    assign result_score      = score_q;

endmodule
`default_nettype wire

// File: tb/tb_classifier_result_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_classifier_result_reader
// Brief    : Directed, table-driven bench for classifier_result_reader.
// Revision : 1.0  initial release
// ============================================================================
module tb_classifier_result_reader;

    localparam int          N     = 10;
    localparam logic [31:0] BASE0 = 32'h0;
    localparam logic [31:0] BASE1 = 32'h100;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_request     [2];
    logic        start_conversion  [2];
    logic        end_of_conversion [2];
    logic        bram_read_enable  [2];
    logic [31:0] bram_read_address [2];
    logic [47:0] bram_read_data    [2];
    logic        busy              [2];
    logic        result_valid      [2];
    logic [3:0]  result_digit      [2];
    logic [47:0] result_score      [2];

    logic [47:0] mem [16];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    classifier_result_reader #(
        .NUM_OUTPUTS(N), .DATA_WIDTH(48), .ADDR_WIDTH(32), .OUTPUT_BASE_ADDRESS(BASE0)
    ) u_dut0 (
        .clk(clk), .reset(reset),
        .start_request(start_request[0]), .start_conversion(start_conversion[0]),
        .end_of_conversion(end_of_conversion[0]),
        .bram_read_enable(bram_read_enable[0]), .bram_read_address(bram_read_address[0]),
        .bram_read_data(bram_read_data[0]), .busy(busy[0]),
        .result_valid(result_valid[0]), .result_digit(result_digit[0]),
        .result_score(result_score[0])
    );

    classifier_result_reader #(
        .NUM_OUTPUTS(N), .DATA_WIDTH(48), .ADDR_WIDTH(32), .OUTPUT_BASE_ADDRESS(BASE1)
    ) u_dut1 (
        .clk(clk), .reset(reset),
        .start_request(start_request[1]), .start_conversion(start_conversion[1]),
        .end_of_conversion(end_of_conversion[1]),
        .bram_read_enable(bram_read_enable[1]), .bram_read_address(bram_read_address[1]),
        .bram_read_data(bram_read_data[1]), .busy(busy[1]),
        .result_valid(result_valid[1]), .result_digit(result_digit[1]),
        .result_score(result_score[1])
    );

    // Synchronous-read BRAM models, addressed relative to each instance's base.
    always @(posedge clk) begin
        if (bram_read_enable[0]) bram_read_data[0] <= mem[4'(bram_read_address[0] - BASE0)];
    end
    always @(posedge clk) begin
        if (bram_read_enable[1]) bram_read_data[1] <= mem[4'(bram_read_address[1] - BASE1)];
    end

    typedef struct {
        logic [0:9][47:0] data;
        logic [3:0]       exp_digit;
        logic [47:0]      exp_score;
        bit               with_start;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load(input int v);
        for (int i = 0; i < 16; i++) mem[i] = (i < N) ? vecs[v].data[i] : 48'h0;
    endtask

    // EOC is presented before edge E; call is made at +1ns after an edge.
    task automatic do_read(input int u, input int v, input bit mid_eoc);
        logic [31:0] base;
        base = (u == 0) ? BASE0 : BASE1;
        load(v);
        end_of_conversion[u] = 1'b1;
        start_request[u]     = vecs[v].with_start;
        tick();                                   // edge E, now cycle E+1
        end_of_conversion[u] = 1'b0;
        start_request[u]     = 1'b0;
        chk("no_start_pulse_on_eoc", 64'(start_conversion[u]), 64'd0);
        for (int k = 0; k < N; k++) begin
            chk("read_enable", 64'(bram_read_enable[u]), 64'd1);
            chk("read_address", 64'(bram_read_address[u]), 64'(base + 32'(k)));
            end_of_conversion[u] = mid_eoc && (k == 3);
            tick();
        end
        end_of_conversion[u] = 1'b0;
        chk("drain_enable_low", 64'(bram_read_enable[u]), 64'd0);
        chk("drain_no_valid", 64'(result_valid[u]), 64'd0);
        tick();                                   // cycle E+N+2
        chk("result_valid", 64'(result_valid[u]), 64'd1);
        chk("result_digit", 64'(result_digit[u]), 64'(vecs[v].exp_digit));
        chk("result_score", 64'(result_score[u]), 64'(vecs[v].exp_score));
        chk("busy_in_done", 64'(busy[u]), 64'd1);
        tick();
        chk("valid_one_cycle", 64'(result_valid[u]), 64'd0);
        chk("busy_falls", 64'(busy[u]), 64'd0);
        chk("digit_held", 64'(result_digit[u]), 64'(vecs[v].exp_digit));
    endtask

    initial begin
        // Vector table
        for (int v = 0; v < 6; v++) begin
            vecs[v].with_start = 1'b0;
            for (int i = 0; i < N; i++) vecs[v].data[i] = 48'h0;
        end
        for (int i = 0; i < N; i++) vecs[0].data[i] = 48'(10 * (i + 1));
        vecs[0].data[7] = 48'd500;
        vecs[0].exp_digit = 4'd7; vecs[0].exp_score = 48'd500;
        vecs[1].data[3] = 48'hFFFF_FFFF_FFFF;
        vecs[1].data[8] = 48'hFFFF_FFFF_FFFF;
        vecs[1].exp_digit = 4'd3; vecs[1].exp_score = 48'hFFFF_FFFF_FFFF;
        for (int i = 0; i < N; i++) vecs[2].data[i] = 48'd5;
        vecs[2].data[0] = 48'd1000;
        vecs[2].exp_digit = 4'd0; vecs[2].exp_score = 48'd1000;
        vecs[2].with_start = 1'b1;
        for (int i = 0; i < N; i++) vecs[3].data[i] = 48'd7;
        vecs[3].data[9] = 48'hFFFF_FFFF_FFFF;
        vecs[3].exp_digit = 4'd9; vecs[3].exp_score = 48'hFFFF_FFFF_FFFF;
        vecs[4].exp_digit = 4'd0; vecs[4].exp_score = 48'd0;
        for (int i = 0; i < N; i++) vecs[5].data[i] = 48'(100 - 10 * i);
        vecs[5].exp_digit = 4'd0; vecs[5].exp_score = 48'd100;

        for (int u = 0; u < 2; u++) begin
            start_request[u]     = 1'b0;
            end_of_conversion[u] = 1'b0;
            bram_read_data[u]    = 48'h0;
        end
        for (int i = 0; i < 16; i++) mem[i] = 48'h0;

        // Reset state
        reset = 1'b0;
        tick();
        tick();
        chk("rst_start_conversion", 64'(start_conversion[0]), 64'd0);
        chk("rst_read_enable", 64'(bram_read_enable[0]), 64'd0);
        chk("rst_read_address", 64'(bram_read_address[1]), 64'd0);
        chk("rst_busy", 64'(busy[0]), 64'd0);
        chk("rst_result_valid", 64'(result_valid[0]), 64'd0);
        chk("rst_result_digit", 64'(result_digit[0]), 64'd0);
        chk("rst_result_score", 64'(result_score[0]), 64'd0);
        reset = 1'b1;
        tick();

        // Start handshake, then a second request while waiting for EOC
        start_request[0] = 1'b1;
        tick();
        start_request[0] = 1'b0;
        chk("start_pulse", 64'(start_conversion[0]), 64'd1);
        chk("busy_after_start", 64'(busy[0]), 64'd1);
        start_request[0] = 1'b1;
        tick();
        start_request[0] = 1'b0;
        chk("start_pulse_one_cycle", 64'(start_conversion[0]), 64'd0);
        tick();
        chk("no_pulse_in_wait_eoc", 64'(start_conversion[0]), 64'd0);
        chk("busy_in_wait_eoc", 64'(busy[0]), 64'd1);
        tick();
        chk("wait_no_read", 64'(bram_read_enable[0]), 64'd0);

        // Table-driven argmax runs on the base-0 instance
        for (int v = 0; v < 6; v++) do_read(0, v, 1'b0);

        // Back-to-back: request accepted in the first IDLE cycle after DONE
        start_request[0] = 1'b1;
        tick();
        start_request[0] = 1'b0;
        chk("b2b_start_pulse", 64'(start_conversion[0]), 64'd1);
        do_read(0, 0, 1'b0);

        // Reset mid-READ: outputs clear asynchronously, no result produced
        load(1);
        end_of_conversion[0] = 1'b1;
        tick();
        end_of_conversion[0] = 1'b0;
        tick();
        tick();
        chk("pre_reset_reading", 64'(bram_read_enable[0]), 64'd1);
        reset = 1'b0;
        #2;
        chk("async_rst_enable", 64'(bram_read_enable[0]), 64'd0);
        chk("async_rst_address", 64'(bram_read_address[0]), 64'd0);
        chk("async_rst_busy", 64'(busy[0]), 64'd0);
        chk("async_rst_digit", 64'(result_digit[0]), 64'd0);
        chk("async_rst_score", 64'(result_score[0]), 64'd0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 14; k++) begin
            chk("post_rst_no_valid", 64'(result_valid[0]), 64'd0);
            chk("post_rst_idle", 64'(busy[0]), 64'd0);
            tick();
        end
        do_read(0, 3, 1'b0);

        // Base offset instance: EOC without start, extra EOC mid-READ ignored
        do_read(1, 0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("no_second_result", 64'(result_valid[1]), 64'd0);
            chk("no_restart", 64'(busy[1]), 64'd0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
